mem_arbiter: RTL and testbench

//   Arbitrates the single byte-serial memory controller between the instruction cache (IF) and
//   the load/store buffer (LSB).

---
 rtl/mem_arbiter.sv | 217 +++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the byte-serial memory controller between the instruction
// cache (IC) and the load/store buffer (LSB). One transaction is in flight at a
// time. The granted request is latched onto mc_*, and the completion pulse and
// data are returned to whichever requester owns the transaction.
//
// Optional feature: define ARB_FAIRNESS_EN to build the starvation guard. After
// STARVE_LIMIT consecutive LSB grants with the IC waiting, the next grant goes
// to the IC. Without the macro the LSB always has priority.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | no transaction in flight; arbitrate eligible requests
// BUSY_IC  | instruction fetch in flight, owner still wants the data
// BUSY_LSB | load/store in flight; jump_flag has no effect
// DRAIN    | fetch made stale by jump_flag; wait for mc_done, drop the data

module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter logic [31:0] IO_ADDR_BASE = 32'h30000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        io_buffer_full,
  input  logic        jump_flag,
  input  logic        ic_req,
  input  logic [31:0] ic_addr,
  output logic        ic_done,
  output logic [31:0] ic_data,
  input  logic        lsb_req,
  input  logic [31:0] lsb_addr,
  input  logic [31:0] lsb_wdata,
  input  logic [2:0]  lsb_size,
  input  logic        lsb_wr,
  output logic        lsb_done,
  output logic [31:0] lsb_data,
  output logic        mc_valid,
  output logic        mc_is_lsb,
  output logic [31:0] mc_addr,
  output logic [31:0] mc_wdata,
  output logic [2:0]  mc_size,
  output logic        mc_wr,
  input  logic        mc_done,
  input  logic [31:0] mc_rdata
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY_IC  = 2'd1,
    BUSY_LSB = 2'd2,
    DRAIN    = 2'd3
  } state_t;

  state_t      state, state_n;

  logic        mc_valid_n;
  logic        mc_is_lsb_n;
  logic [31:0] mc_addr_n;
  logic [31:0] mc_wdata_n;
  logic [2:0]  mc_size_n;
  logic        mc_wr_n;
  logic        ic_done_n;
  logic [31:0] ic_data_n;
  logic        lsb_done_n;
  logic [31:0] lsb_data_n;

  logic        lsb_elig;
  logic        ic_elig;
  logic        ic_forced;
  logic        grant_lsb;
  logic        grant_ic;

  // An IO-space store cannot start while the UART buffer is full; a fetch
  // requested in the same cycle as a redirect is already stale.
  assign lsb_elig = lsb_req &&
                    !(lsb_wr && (lsb_addr >= IO_ADDR_BASE) && io_buffer_full);
  assign ic_elig  = ic_req && !jump_flag;

`ifdef ARB_FAIRNESS_EN
  localparam logic [2:0] STARVE_MAX = 3'(STARVE_LIMIT);

  logic [2:0] starve_cnt, starve_cnt_n;

  assign ic_forced = (starve_cnt == STARVE_MAX) && ic_elig;
`else
  assign ic_forced = 1'b0;
`endif

  assign grant_lsb = lsb_elig && !ic_forced;
  assign grant_ic  = ic_elig && !grant_lsb;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state and next-output decode; rdy low parks the arbiter in IDLE.
  always_comb begin
    state_n     = state;
    mc_valid_n  = mc_valid;
    mc_is_lsb_n = mc_is_lsb;
    mc_addr_n   = mc_addr;
    mc_wdata_n  = mc_wdata;
    mc_size_n   = mc_size;
    mc_wr_n     = mc_wr;
    ic_done_n   = 1'b0;
    ic_data_n   = ic_data;
    lsb_done_n  = 1'b0;
    lsb_data_n  = lsb_data;

    if (!rdy) begin
      state_n    = IDLE;
      mc_valid_n = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          mc_valid_n = 1'b0;
          if (grant_lsb) begin
            mc_valid_n  = 1'b1;
            mc_is_lsb_n = 1'b1;
            mc_addr_n   = lsb_addr;
            mc_wdata_n  = lsb_wdata;
            mc_size_n   = lsb_size;
            mc_wr_n     = lsb_wr;
            state_n     = BUSY_LSB;
          end else if (grant_ic) begin
            mc_valid_n  = 1'b1;
            mc_is_lsb_n = 1'b0;
            mc_addr_n   = ic_addr;
            mc_wdata_n  = 32'd0;
            mc_size_n   = 3'd4;
            mc_wr_n     = 1'b0;
            state_n     = BUSY_IC;
          end
        end
        BUSY_LSB: begin
          if (mc_done) begin
            lsb_done_n = 1'b1;
            lsb_data_n = mc_rdata;
            mc_valid_n = 1'b0;
            state_n    = IDLE;
          end
        end
        BUSY_IC: begin
          if (mc_done) begin
            // A redirect arriving with the data makes it stale: drop it.
            ic_done_n  = !jump_flag;
            ic_data_n  = jump_flag ? ic_data : mc_rdata;
            mc_valid_n = 1'b0;
            state_n    = IDLE;
          end else if (jump_flag) begin
            state_n = DRAIN;
          end
        end
        DRAIN: begin
          // The controller cannot abort mid-transfer, so keep mc_valid up.
          if (mc_done) begin
            mc_valid_n = 1'b0;
            state_n    = IDLE;
          end
        end
        default: begin
          mc_valid_n = 1'b0;
          state_n    = IDLE;
        end
      endcase
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      mc_valid  <= 1'b0;
      mc_is_lsb <= 1'b0;
      mc_addr   <= 32'd0;
      mc_wdata  <= 32'd0;
      mc_size   <= 3'd0;
      mc_wr     <= 1'b0;
      ic_done   <= 1'b0;
      ic_data   <= 32'd0;
      lsb_done  <= 1'b0;
      lsb_data  <= 32'd0;
    end else begin
      mc_valid  <= mc_valid_n;
      mc_is_lsb <= mc_is_lsb_n;
      mc_addr   <= mc_addr_n;
      mc_wdata  <= mc_wdata_n;
      mc_size   <= mc_size_n;
      mc_wr     <= mc_wr_n;
      ic_done   <= ic_done_n;
      ic_data   <= ic_data_n;
      lsb_done  <= lsb_done_n;
      lsb_data  <= lsb_data_n;
    end
  end

`ifdef ARB_FAIRNESS_EN
  // Starvation counter: counts LSB wins while the IC waits, saturating.
  always_comb begin
    starve_cnt_n = starve_cnt;
    if (rdy && (state == IDLE)) begin
      if (grant_ic || !ic_req)
        starve_cnt_n = 3'd0;
      else if (grant_lsb && (starve_cnt < STARVE_MAX))
        starve_cnt_n = starve_cnt + 3'd1;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk) begin
    if (rst) starve_cnt <= 3'd0;
    else     starve_cnt <= starve_cnt_n;
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter. Inputs are driven and
// outputs sampled 1 time unit after each rising clock edge.
`timescale 1ns/1ps

module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst, rdy, io_buffer_full, jump_flag;
  logic        ic_req;
  logic [31:0] ic_addr;
  logic        ic_done;
  logic [31:0] ic_data;
  logic        lsb_req;
  logic [31:0] lsb_addr, lsb_wdata;
  logic [2:0]  lsb_size;
  logic        lsb_wr;
  logic        lsb_done;
  logic [31:0] lsb_data;
  logic        mc_valid, mc_is_lsb;
  logic [31:0] mc_addr, mc_wdata;
  logic [2:0]  mc_size;
  logic        mc_wr;
  logic        mc_done;
  logic [31:0] mc_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.STARVE_LIMIT(4), .IO_ADDR_BASE(32'h30000)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .io_buffer_full(io_buffer_full),
    .jump_flag(jump_flag), .ic_req(ic_req), .ic_addr(ic_addr),
    .ic_done(ic_done), .ic_data(ic_data), .lsb_req(lsb_req),
    .lsb_addr(lsb_addr), .lsb_wdata(lsb_wdata), .lsb_size(lsb_size),
    .lsb_wr(lsb_wr), .lsb_done(lsb_done), .lsb_data(lsb_data),
    .mc_valid(mc_valid), .mc_is_lsb(mc_is_lsb), .mc_addr(mc_addr),
    .mc_wdata(mc_wdata), .mc_size(mc_size), .mc_wr(mc_wr),
    .mc_done(mc_done), .mc_rdata(mc_rdata)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mc_finish(input logic [31:0] d);
    mc_done  = 1'b1;
    mc_rdata = d;
    step();
    mc_done  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rdy = 1'b1; io_buffer_full = 1'b0; jump_flag = 1'b0;
    ic_req = 1'b0; ic_addr = 32'd0; lsb_req = 1'b0; lsb_addr = 32'd0;
    lsb_wdata = 32'd0; lsb_size = 3'd0; lsb_wr = 1'b0;
    mc_done = 1'b0; mc_rdata = 32'd0;
    step(); step();
    checks++;
    if ({mc_valid, ic_done, lsb_done, mc_is_lsb, mc_wr} !== 5'b0) begin
      errors++; $display("FAIL reset_flags got %b want 00000", {mc_valid, ic_done, lsb_done, mc_is_lsb, mc_wr});
    end
    checks++;
    if ({mc_addr, mc_wdata, mc_size, ic_data, lsb_data} !== 131'd0) begin
      errors++; $display("FAIL reset_data got addr=%h wdata=%h size=%0d icd=%h lsbd=%h want all 0", mc_addr, mc_wdata, mc_size, ic_data, lsb_data);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_ic_only();
    ic_req = 1'b1; ic_addr = 32'h100;
    step();
    checks++;
    if ({mc_valid, mc_is_lsb, mc_addr, mc_size, mc_wr} !== {1'b1, 1'b0, 32'h100, 3'd4, 1'b0}) begin
      errors++; $display("FAIL ic_grant got v=%b lsb=%b addr=%h size=%0d wr=%b want 1 0 100 4 0", mc_valid, mc_is_lsb, mc_addr, mc_size, mc_wr);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (mc_valid !== 1'b1 || ic_done !== 1'b0) begin
        errors++; $display("FAIL ic_hold%0d got v=%b done=%b want 1 0", i, mc_valid, ic_done);
      end
    end
    mc_finish(32'h00c58593);
    ic_req = 1'b0;
    checks++;
    if ({ic_done, mc_valid, lsb_done} !== 3'b100 || ic_data !== 32'h00c58593) begin
      errors++; $display("FAIL ic_done got done=%b v=%b lsbd=%b data=%h want 1 0 0 00c58593", ic_done, mc_valid, lsb_done, ic_data);
    end
    step();
    checks++;
    if (ic_done !== 1'b0 || mc_valid !== 1'b0) begin
      errors++; $display("FAIL ic_single_pulse got done=%b v=%b want 0 0", ic_done, mc_valid);
    end
  endtask

  task automatic test_lsb_first();
    ic_req = 1'b1; ic_addr = 32'h104;
    lsb_req = 1'b1; lsb_addr = 32'h2000; lsb_size = 3'd2; lsb_wr = 1'b0; lsb_wdata = 32'h0;
    step();
    checks++;
    if ({mc_valid, mc_is_lsb, mc_addr, mc_size, mc_wr} !== {1'b1, 1'b1, 32'h2000, 3'd2, 1'b0}) begin
      errors++; $display("FAIL lsb_first_grant got v=%b lsb=%b addr=%h size=%0d wr=%b want 1 1 2000 2 0", mc_valid, mc_is_lsb, mc_addr, mc_size, mc_wr);
    end
    step();
    mc_finish(32'h0000beef);
    lsb_req = 1'b0;
    checks++;
    if ({lsb_done, ic_done, mc_valid} !== 3'b100 || lsb_data !== 32'h0000beef) begin
      errors++; $display("FAIL lsb_done got lsbd=%b icd=%b v=%b data=%h want 1 0 0 0000beef", lsb_done, ic_done, mc_valid, lsb_data);
    end
    step();
    checks++;
    if ({mc_valid, mc_is_lsb, mc_addr} !== {1'b1, 1'b0, 32'h104}) begin
      errors++; $display("FAIL ic_after_lsb got v=%b lsb=%b addr=%h want 1 0 104", mc_valid, mc_is_lsb, mc_addr);
    end
    mc_finish(32'h11112222);
    ic_req = 1'b0;
    checks++;
    if (ic_done !== 1'b1 || ic_data !== 32'h11112222) begin
      errors++; $display("FAIL ic_after_lsb_done got done=%b data=%h want 1 11112222", ic_done, ic_data);
    end
    step();
  endtask

  task automatic test_jump();
    // Redirect mid-fetch: the transfer drains, no ic_done.
    ic_req = 1'b1; ic_addr = 32'h200;
    step(); step();
    jump_flag = 1'b1; ic_req = 1'b0;
    step();
    jump_flag = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (mc_valid !== 1'b1 || ic_done !== 1'b0) begin
        errors++; $display("FAIL drain_hold%0d got v=%b done=%b want 1 0", i, mc_valid, ic_done);
      end
      step();
    end
    mc_finish(32'hdeadbeef);
    checks++;
    if ({mc_valid, ic_done} !== 2'b00 || ic_data !== 32'h11112222) begin
      errors++; $display("FAIL drain_end got v=%b done=%b data=%h want 0 0 11112222", mc_valid, ic_done, ic_data);
    end
    step();
    checks++;
    if (mc_valid !== 1'b0) begin
      errors++; $display("FAIL drain_idle got v=%b want 0", mc_valid);
    end
    // Redirect in IDLE blocks the fetch for that cycle.
    ic_req = 1'b1; ic_addr = 32'h300; jump_flag = 1'b1;
    step();
    jump_flag = 1'b0;
    checks++;
    if (mc_valid !== 1'b0) begin
      errors++; $display("FAIL jump_idle_block got v=%b want 0", mc_valid);
    end
    step();
    checks++;
    if (mc_valid !== 1'b1 || mc_addr !== 32'h300) begin
      errors++; $display("FAIL jump_idle_regrant got v=%b addr=%h want 1 300", mc_valid, mc_addr);
    end
    mc_finish(32'hcafe0001);
    ic_req = 1'b0;
    checks++;
    if (ic_done !== 1'b1 || ic_data !== 32'hcafe0001) begin
      errors++; $display("FAIL jump_idle_done got done=%b data=%h want 1 cafe0001", ic_done, ic_data);
    end
    step();
    // Redirect together with mc_done: data dropped.
    ic_req = 1'b1; ic_addr = 32'h204;
    step(); step();
    mc_done = 1'b1; mc_rdata = 32'h55555555; jump_flag = 1'b1; ic_req = 1'b0;
    step();
    mc_done = 1'b0; jump_flag = 1'b0;
    checks++;
    if ({ic_done, mc_valid} !== 2'b00 || ic_data !== 32'hcafe0001) begin
      errors++; $display("FAIL jump_with_done got done=%b v=%b data=%h want 0 0 cafe0001", ic_done, mc_valid, ic_data);
    end
    step();
  endtask

  task automatic test_io_hold();
    io_buffer_full = 1'b1;
    lsb_req = 1'b1; lsb_wr = 1'b1; lsb_addr = 32'h30000; lsb_wdata = 32'h41; lsb_size = 3'd1;
    ic_req = 1'b1; ic_addr = 32'h400;
    step();
    checks++;
    if ({mc_valid, mc_is_lsb, mc_addr} !== {1'b1, 1'b0, 32'h400}) begin
      errors++; $display("FAIL io_ic_served got v=%b lsb=%b addr=%h want 1 0 400", mc_valid, mc_is_lsb, mc_addr);
    end
    step();
    mc_finish(32'h0badf00d);
    ic_req = 1'b0;
    checks++;
    if (ic_done !== 1'b1) begin
      errors++; $display("FAIL io_ic_done got %b want 1", ic_done);
    end
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (mc_valid !== 1'b0) begin
        errors++; $display("FAIL io_store_held%0d got v=%b want 0", i, mc_valid);
      end
    end
    io_buffer_full = 1'b0;
    step();
    checks++;
    if ({mc_valid, mc_is_lsb, mc_addr, mc_wdata, mc_size, mc_wr} !== {1'b1, 1'b1, 32'h30000, 32'h41, 3'd1, 1'b1}) begin
      errors++; $display("FAIL io_store_grant got v=%b lsb=%b addr=%h wd=%h size=%0d wr=%b want 1 1 30000 41 1 1", mc_valid, mc_is_lsb, mc_addr, mc_wdata, mc_size, mc_wr);
    end
    mc_finish(32'h0);
    lsb_req = 1'b0;
    checks++;
    if (lsb_done !== 1'b1) begin
      errors++; $display("FAIL io_store_done got %b want 1", lsb_done);
    end
    step();
    // Just below the IO base the store is not held.
    io_buffer_full = 1'b1;
    lsb_req = 1'b1; lsb_addr = 32'h2fffc; lsb_wdata = 32'h12345678; lsb_size = 3'd4;
    step();
    checks++;
    if ({mc_valid, mc_is_lsb, mc_addr, mc_wdata} !== {1'b1, 1'b1, 32'h2fffc, 32'h12345678}) begin
      errors++; $display("FAIL below_io_grant got v=%b lsb=%b addr=%h wd=%h want 1 1 2fffc 12345678", mc_valid, mc_is_lsb, mc_addr, mc_wdata);
    end
    mc_finish(32'h0);
    lsb_req = 1'b0; io_buffer_full = 1'b0; lsb_wr = 1'b0;
    step();
  endtask

  task automatic test_priority();
    logic exp_lsb;
    rst = 1'b1;
    step();
    rst = 1'b0;
    lsb_req = 1'b1; lsb_addr = 32'h1000; lsb_wr = 1'b0; lsb_size = 3'd1;
    ic_req = 1'b1; ic_addr = 32'h500;
    for (int i = 0; i < 6; i++) begin
      int n = 0;
      while (mc_valid !== 1'b1 && n < 4) begin
        step();
        n++;
      end
      exp_lsb = 1'b1;
`ifdef ARB_FAIRNESS_EN
      if (i == 4) exp_lsb = 1'b0;
`endif
      checks++;
      if (mc_valid !== 1'b1 || mc_is_lsb !== exp_lsb) begin
        errors++; $display("FAIL grant_order%0d got v=%b lsb=%b want 1 %b", i, mc_valid, mc_is_lsb, exp_lsb);
      end
      mc_finish(32'(i));
      checks++;
      if ({lsb_done, ic_done} !== {exp_lsb, ~exp_lsb}) begin
        errors++; $display("FAIL done_route%0d got lsbd=%b icd=%b want %b %b", i, lsb_done, ic_done, exp_lsb, ~exp_lsb);
      end
    end
    lsb_req = 1'b0; ic_req = 1'b0;
    step(); step();
  endtask

  task automatic test_rdy_rst();
    lsb_req = 1'b1; lsb_addr = 32'h1800; lsb_wr = 1'b0; lsb_size = 3'd4;
    step();
    checks++;
    if (mc_valid !== 1'b1 || mc_addr !== 32'h1800) begin
      errors++; $display("FAIL pause_setup got v=%b addr=%h want 1 1800", mc_valid, mc_addr);
    end
    rdy = 1'b0;
    step(); step();
    checks++;
    if ({mc_valid, lsb_done} !== 2'b00 || mc_addr !== 32'h1800) begin
      errors++; $display("FAIL rdy_low got v=%b done=%b addr=%h want 0 0 1800", mc_valid, lsb_done, mc_addr);
    end
    rdy = 1'b1;
    step();
    checks++;
    if (mc_valid !== 1'b1 || mc_is_lsb !== 1'b1) begin
      errors++; $display("FAIL rdy_regrant got v=%b lsb=%b want 1 1", mc_valid, mc_is_lsb);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({mc_valid, lsb_done} !== 2'b00 || mc_addr !== 32'h0) begin
      errors++; $display("FAIL rst_busy got v=%b done=%b addr=%h want 0 0 0", mc_valid, lsb_done, mc_addr);
    end
    step();
    checks++;
    if (mc_valid !== 1'b1 || mc_addr !== 32'h1800) begin
      errors++; $display("FAIL rst_regrant got v=%b addr=%h want 1 1800", mc_valid, mc_addr);
    end
    mc_finish(32'h87654321);
    lsb_req = 1'b0;
    checks++;
    if (lsb_done !== 1'b1 || lsb_data !== 32'h87654321) begin
      errors++; $display("FAIL rst_final_done got done=%b data=%h want 1 87654321", lsb_done, lsb_data);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_ic_only();
    test_lsb_first();
    test_jump();
    test_io_hold();
    test_priority();
    test_rdy_rst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
